// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared mode encodings and width helper for the moving-average filter
package moving_average_pkg;

  // Output mode encodings, sampled alongside each accepted sample
  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Running-sum/output width: enough to hold N full-scale samples without overflow
  function automatic int out_width(input int w, input int log2_n);
    return w + log2_n;
  endfunction

endpackage

// File: rtl/avg_window_buf.sv
// rtl/avg_window_buf.sv - circular sample buffer with write pointer and saturating fill count
module avg_window_buf #(
  parameter int W      = 4,
  parameter int LOG2_N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] oldest,
  output logic         full,
  output logic         near_full
);

  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N:0] N_CNT  = (LOG2_N + 1)'(N);
  localparam logic [LOG2_N:0] N_LAST = (LOG2_N + 1)'(N - 1);

  logic [W-1:0]      mem [N];
  logic [LOG2_N-1:0] wp;
  logic [LOG2_N:0]   cnt;

  // Entries start at zero so the subtraction of the evicted sample is exact during fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (wr_en) begin
      mem[wp] <= din;
      wp      <= wp + 1'b1;
      if (cnt != N_CNT) cnt <= cnt + 1'b1;
    end
  end

  // The slot about to be overwritten holds the sample leaving the window
  assign oldest    = mem[wp];
  assign full      = (cnt == N_CNT);
  // One more sample completes the window: the next accept produces a valid result
  assign near_full = (cnt == N_LAST);

endmodule

// File: rtl/moving_average.sv
// rtl/moving_average.sv - running-sum moving-average filter over the last 2^LOG2_N samples
module moving_average
  import moving_average_pkg::*;
#(
  parameter int W      = 4,
  parameter int LOG2_N = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                x_load,
  input  logic [W-1:0]                        x,
  input  logic                                clr,
  input  logic                                mode,
  output logic [out_width(W, LOG2_N)-1:0]     y,
  output logic                                y_valid,
  output logic                                full
);

  localparam int OW = out_width(W, LOG2_N);
  // Half an LSB of the integer average, for round-half-up
  localparam logic [OW-1:0] HALF = OW'(1) << (LOG2_N - 1);

  logic [OW-1:0] s;
  logic [OW-1:0] s_next;
  logic [OW-1:0] rounded;
  logic [W-1:0]  oldest;
  logic          near_full;

  avg_window_buf #(
    .W      (W),
    .LOG2_N (LOG2_N)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_en     (x_load),
    .din       (x),
    .oldest    (oldest),
    .full      (full),
    .near_full (near_full)
  );

  // One add and one subtract per sample; s never exceeds N*(2^W-1), and adding HALF stays in range
  always_comb begin
    s_next  = s + OW'(x) - OW'(oldest);
    rounded = (s_next + HALF) >> LOG2_N;
  end

  // Running sum and registered output; clr wins over a concurrent sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else if (clr) begin
      s       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (x_load) begin
        s       <= s_next;
        y       <= (mode == MODE_AVG) ? rounded : s_next;
        y_valid <= full | near_full;
      end
    end
  end

endmodule
